cl2st_before_afu: RTL



---
 rtl/cl_pkg.sv | 40 ++++
 rtl/cl_head_decode.sv | 20 ++
 rtl/cl2st_before_afu.sv | 106 ++++++++++
 3 files changed

// File: rtl/cl_pkg.sv
// Shared cache-line definitions: head layout, widths and the length
// range check, common to the CL-to-ST stage before the AFU and the
// ST-to-CL stage after it.
package cl_pkg;

    localparam int CL           = 512;
    localparam int CL_HEAD      = 16;
    localparam int CL_PAYLOAD   = 496;
    localparam int w_len_CLHead = 10;
    localparam int ST1          = 8;

    localparam logic [w_len_CLHead-1:0] MaxNumOfST_inCL = 10'd41;

    // Head bit positions, counted within the full cache line
    localparam int CL_SOP_BIT = CL - 5;
    localparam int CL_EOP_BIT = CL - 6;
    localparam int CL_LEN_LSB = CL - CL_HEAD;

    // Number of ST words the payload field can physically hold
    localparam int NUM_WORDS = CL_PAYLOAD / ST1;

    // Head field, top CL_HEAD bits of a cache line
    typedef struct packed {
        logic [CL_HEAD-w_len_CLHead-3:0] rsvd;
        logic                            sop;
        logic                            eop;
        logic [w_len_CLHead-1:0]         len;
    } cl_head_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } cl2st_state_t;

    // A line must carry between 1 and MaxNumOfST_inCL words
    function automatic logic len_out_of_range(input logic [w_len_CLHead-1:0] len);
        return (len == '0) || (len > MaxNumOfST_inCL);
    endfunction

endpackage

// File: rtl/cl_head_decode.sv
// Combinational cache-line head decoder: pulls sop, eop and len out of the
// head bits and flags a length that the line cannot legally carry.
module cl_head_decode
    import cl_pkg::*;
(
    input  logic [CL_HEAD-1:0] head_bits,
    output cl_head_t           head,
    output logic               len_bad
);

    // Head bits are handed over already stripped of the payload, so the
    // line-relative offsets are rebased onto CL_LEN_LSB.
    assign head.rsvd = head_bits[CL_HEAD-1 -: (CL_HEAD-w_len_CLHead-2)];
    assign head.sop  = head_bits[CL_SOP_BIT-CL_LEN_LSB];
    assign head.eop  = head_bits[CL_EOP_BIT-CL_LEN_LSB];
    assign head.len  = head_bits[w_len_CLHead-1:0];

    assign len_bad = len_out_of_range(head.len);

endmodule

// File: rtl/cl2st_before_afu.sv
// Cache-line to ST converter ahead of the AFU. Pops lines from a show-ahead
// FIFO and streams their payload out as ST1-bit words, lowest bits first,
// regenerating sop/eop from the head flags.
// Optional build macro: CL2ST_LEN_CHECK_EN -- drop lines with an illegal
// length and raise a sticky err_len; otherwise such lengths are clamped
// to MaxNumOfST_inCL.
module cl2st_before_afu
    import cl_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [CL-1:0]  ff_q,
    input  logic           ff_empty,
    output logic           ff_rdreq,
    input  logic           source_ready,
    output logic           source_valid,
    output logic [ST1-1:0] source_data,
    output logic           source_sop,
    output logic           source_eop,
    output logic           busy,
    output logic           err_len
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [w_len_CLHead-1:0] ONE = 1;

    cl2st_state_t                          state;
    logic [w_len_CLHead-1:0]               idx;
    logic [w_len_CLHead-1:0]               len_reg;
    logic                                  sop_reg;
    logic                                  eop_reg;
    logic [NUM_WORDS-1:0][ST1-1:0]         payload_reg;

    cl_head_t                              head;
    logic                                  head_len_bad;
    logic [w_len_CLHead-1:0]               load_len;
    logic                                  last_beat;
    logic                                  last_xfer;
    logic                                  unused_head_rsvd;

    cl_head_decode u_head_decode (
        .head_bits (ff_q[CL-1:CL_LEN_LSB]),
        .head      (head),
        .len_bad   (head_len_bad)
    );

    assign unused_head_rsvd = ^head.rsvd;

`ifdef CL2ST_LEN_CHECK_EN
    logic err_len_reg;
    assign load_len = head.len;
    assign err_len  = err_len_reg;
`else
    assign load_len = head_len_bad ? MaxNumOfST_inCL : head.len;
    assign err_len  = 1'b0;
`endif

    assign busy         = (state == SEND);
    assign source_valid = busy;
    assign source_data  = payload_reg[idx[IDX_W-1:0]];
    assign last_beat    = (idx == len_reg - ONE);
    assign source_sop   = busy && sop_reg && (idx == '0);
    assign source_eop   = busy && eop_reg && last_beat;
    assign last_xfer    = busy && source_ready && last_beat;
    // The next line is popped on the same edge the current last word leaves,
    // so back-to-back lines stream without a bubble.
    assign ff_rdreq     = rst_n && !ff_empty && ((state == IDLE) || last_xfer);

    // Line-holding FSM: load on pop, step idx on each transfer, drop back to
    // IDLE once the last word goes out with nothing left to pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            len_reg     <= '0;
            sop_reg     <= 1'b0;
            eop_reg     <= 1'b0;
            payload_reg <= '0;
`ifdef CL2ST_LEN_CHECK_EN
            err_len_reg <= 1'b0;
`endif
        end else if (ff_rdreq) begin
`ifdef CL2ST_LEN_CHECK_EN
            if (head_len_bad) begin
                state       <= IDLE;
                idx         <= '0;
                err_len_reg <= 1'b1;
            end else
`endif
            begin
                state       <= SEND;
                idx         <= '0;
                len_reg     <= load_len;
                sop_reg     <= head.sop;
                eop_reg     <= head.eop;
                payload_reg <= ff_q[CL_PAYLOAD-1:0];
            end
        end else if (last_xfer) begin
            state <= IDLE;
            idx   <= '0;
        end else if (busy && source_ready) begin
            idx <= idx + ONE;
        end
    end

endmodule
